// File: rtl/captura_pixeles_pkg.sv
// Shared definitions for the pixel capture block: FSM encoding, output
// format codes and the packed-pixel width derivation.
package captura_pixeles_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam int unsigned FMT_RGB332 = 0;
    localparam int unsigned FMT_RGB444 = 1;
    localparam int unsigned FMT_RGB565 = 2;

    // Packed pixel width for a given output format code
    function automatic int unsigned dw_of(input int unsigned fmt);
        case (fmt)
            FMT_RGB444: return 12;
            FMT_RGB565: return 16;
            default:    return 8;
        endcase
    endfunction

endpackage

// File: rtl/captura_pixeles_empaquetador.sv
// Combinational repacker: two RGB565 sensor bytes -> output pixel format.
module pixel_empaquetador
    import captura_pixeles_pkg::*;
#(
    parameter int unsigned OUT_FMT = FMT_RGB332,
    parameter int unsigned DW      = dw_of(OUT_FMT)
) (
    input  logic [7:0]    b1,
    input  logic [7:0]    b2,
    output logic [DW-1:0] pix_c
);

    // Select the bit gather for the configured format; dropped LSBs are truncated
    generate
        if (OUT_FMT == FMT_RGB565) begin : g_565
            assign pix_c = DW'({b1, b2});
        end else if (OUT_FMT == FMT_RGB444) begin : g_444
            logic unused_c;
            assign pix_c    = DW'({b1[7:4], b1[2:0], b2[7], b2[4:1]});
            assign unused_c = ^{b1[3], b2[6:5], b2[0]};
        end else begin : g_332
            logic unused_c;
            assign pix_c    = DW'({b1[7:5], b1[2:0], b2[4:3]});
            assign unused_c = ^{b1[4:3], b2[7:5], b2[2:0]};
        end
    endgenerate

endmodule

// File: rtl/captura_pixeles.sv
// Camera sensor capture: RGB565 byte stream -> frame-buffer write port.
// Optional macro CAPTURA_DECIM_EN enables 2:1 decimation on both axes.
module captura_pixeles
    import captura_pixeles_pkg::*;
#(
    parameter int unsigned H_PIX   = 160,
    parameter int unsigned V_PIX   = 120,
    parameter int unsigned AW      = 15,
    parameter int unsigned OUT_FMT = FMT_RGB332
) (
    input  logic                         Pclk,
    input  logic                         Rst_n,
    input  logic                         Vsync,
    input  logic                         Href,
    input  logic [7:0]                   D,
    input  logic                         Enable,
    input  logic                         Single,
    output logic [AW-1:0]                addr,
    output logic [dw_of(OUT_FMT)-1:0]    data,
    output logic                         write,
    output logic                         frame_done,
    output logic                         line_err,
    output logic                         busy
);

    localparam int unsigned DW = dw_of(OUT_FMT);

`ifdef CAPTURA_DECIM_EN
    // col counts stored pixels; spix counts sensor pixels for the line check
    localparam int unsigned    SCW    = $clog2(2 * H_PIX + 2);
    localparam int unsigned    CW     = $clog2(H_PIX + 1);
    localparam logic [SCW-1:0] S_LINE = SCW'(2 * H_PIX);
    localparam logic [SCW-1:0] S_MAX  = SCW'(2 * H_PIX + 1);
`else
    // col counts sensor pixels, saturating one past a full line
    localparam int unsigned    CW     = $clog2(H_PIX + 2);
    localparam logic [CW-1:0]  C_MAX  = CW'(H_PIX + 1);
`endif
    localparam logic [CW-1:0]  C_LIM     = CW'(H_PIX);
    localparam int unsigned    RW        = $clog2(V_PIX + 1);
    localparam logic [RW-1:0]  R_LIM     = RW'(V_PIX);
    localparam logic [RW-1:0]  R_LAST    = RW'(V_PIX - 1);
    localparam logic [AW-1:0]  BASE_STEP = AW'(H_PIX);

    state_e          state_q, state_d;
    logic            vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic            hr_q, hr_d, hr_prev_q, hr_prev_d;
    logic [7:0]      d_q, d_d;
    logic [7:0]      b1_q, b1_d;
    logic            phase_q, phase_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            write_q, write_d;
    logic            done_q, done_d;
    logic            lerr_q, lerr_d;
    logic            busy_q, busy_d;
`ifdef CAPTURA_DECIM_EN
    logic [SCW-1:0]  spix_q, spix_d;
    logic            lpar_q, lpar_d;
`endif

    logic            vs_rise_c, vs_fall_c, hr_fall_c;
    logic [DW-1:0]   pix_c;

    pixel_empaquetador #(
        .OUT_FMT (OUT_FMT),
        .DW      (DW)
    ) u_empaquetador (
        .b1    (b1_q),
        .b2    (d_q),
        .pix_c (pix_c)
    );

    // Edges are taken only from the registered sync copies
    assign vs_rise_c = ~vs_prev_q & vs_q;
    assign vs_fall_c = vs_prev_q & ~vs_q;
    assign hr_fall_c = hr_prev_q & ~hr_q;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d   = state_q;
        vs_d      = Vsync;
        hr_d      = Href;
        vs_prev_d = vs_q;
        hr_prev_d = hr_q;
        d_d       = D;
        b1_d      = b1_q;
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        base_d    = base_q;
        addr_d    = addr_q;
        data_d    = data_q;
        write_d   = 1'b0;
        done_d    = 1'b0;
        lerr_d    = lerr_q;
`ifdef CAPTURA_DECIM_EN
        spix_d    = spix_q;
        lpar_d    = lpar_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (Enable) begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!Enable) begin
                    state_d = ST_IDLE;
                end else if (vs_fall_c) begin
                    state_d = ST_CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    base_d  = '0;
                    phase_d = 1'b0;
                    lerr_d  = 1'b0;
`ifdef CAPTURA_DECIM_EN
                    spix_d  = '0;
                    lpar_d  = 1'b0;
`endif
                end
            end

            ST_CAPTURE: begin
                if (vs_rise_c) begin
                    // Frame end wins over any half-formed pixel
                    done_d  = 1'b1;
                    phase_d = 1'b0;
                    state_d = (Single || !Enable) ? ST_IDLE : ST_ARMED;
                end else if (hr_fall_c) begin
`ifdef CAPTURA_DECIM_EN
                    if ((row_q < R_LIM) && ((spix_q != S_LINE) || phase_q)) begin
                        lerr_d = 1'b1;
                    end
                    spix_d = '0;
                    lpar_d = ~lpar_q;
                    if (!lpar_q && (row_q < R_LIM)) begin
                        row_d = row_q + RW'(1);
                        if (row_q < R_LAST) begin
                            base_d = base_q + BASE_STEP;
                        end
                    end
`else
                    if ((row_q < R_LIM) && ((col_q != C_LIM) || phase_q)) begin
                        lerr_d = 1'b1;
                    end
                    if (row_q < R_LIM) begin
                        row_d = row_q + RW'(1);
                        if (row_q < R_LAST) begin
                            base_d = base_q + BASE_STEP;
                        end
                    end
`endif
                    col_d   = '0;
                    phase_d = 1'b0;
                end else if (hr_q) begin
                    if (!phase_q) begin
                        b1_d    = d_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
`ifdef CAPTURA_DECIM_EN
                        if (!spix_q[0] && !lpar_q && (col_q < C_LIM) && (row_q < R_LIM)) begin
                            write_d = 1'b1;
                            addr_d  = base_q + AW'(col_q);
                            data_d  = pix_c;
                            col_d   = col_q + CW'(1);
                        end
                        if (spix_q != S_MAX) begin
                            spix_d = spix_q + SCW'(1);
                        end
`else
                        if ((col_q < C_LIM) && (row_q < R_LIM)) begin
                            write_d = 1'b1;
                            addr_d  = base_q + AW'(col_q);
                            data_d  = pix_c;
                        end
                        if (col_q != C_MAX) begin
                            col_d = col_q + CW'(1);
                        end
`endif
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Pclk) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            vs_q      <= 1'b0;
            hr_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            hr_prev_q <= 1'b0;
            d_q       <= '0;
            b1_q      <= '0;
            phase_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            done_q    <= 1'b0;
            lerr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef CAPTURA_DECIM_EN
            spix_q    <= '0;
            lpar_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            vs_q      <= vs_d;
            hr_q      <= hr_d;
            vs_prev_q <= vs_prev_d;
            hr_prev_q <= hr_prev_d;
            d_q       <= d_d;
            b1_q      <= b1_d;
            phase_q   <= phase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            done_q    <= done_d;
            lerr_q    <= lerr_d;
            busy_q    <= busy_d;
`ifdef CAPTURA_DECIM_EN
            spix_q    <= spix_d;
            lpar_q    <= lpar_d;
`endif
        end
    end

    assign addr       = addr_q;
    assign data       = data_q;
    assign write      = write_q;
    assign frame_done = done_q;
    assign line_err   = lerr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_captura_pixeles.sv
// Scoreboard bench: two captures (RGB332 and RGB565) on a 4x2 frame buffer.
module tb_captura_pixeles;

    typedef struct packed {
        logic [2:0]  a;
        logic [7:0]  d8;
        logic [15:0] d16;
    } exp_t;

    logic        Pclk = 1'b0;
    logic        Rst_n, Vsync, Href, Enable, Single;
    logic [7:0]  D;

    logic [2:0]  addr8, addr16;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        write8, write16, done8, done16, lerr8, lerr16, busy8, busy16;

    exp_t        q8[$];
    exp_t        q16[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_cnt8 = 0;
    int          wr_cnt16 = 0;
    int          done_cnt = 0;
    int          done_cnt16 = 0;
    logic [2:0]  last_a8 = '0;
    logic [2:0]  last_a16 = '0;

    always #5 Pclk = ~Pclk;

    captura_pixeles #(.H_PIX(4), .V_PIX(2), .AW(3), .OUT_FMT(0)) u_dut8 (
        .Pclk(Pclk), .Rst_n(Rst_n), .Vsync(Vsync), .Href(Href), .D(D),
        .Enable(Enable), .Single(Single), .addr(addr8), .data(data8),
        .write(write8), .frame_done(done8), .line_err(lerr8), .busy(busy8)
    );

    captura_pixeles #(.H_PIX(4), .V_PIX(2), .AW(3), .OUT_FMT(2)) u_dut16 (
        .Pclk(Pclk), .Rst_n(Rst_n), .Vsync(Vsync), .Href(Href), .D(D),
        .Enable(Enable), .Single(Single), .addr(addr16), .data(data16),
        .write(write16), .frame_done(done16), .line_err(lerr16), .busy(busy16)
    );

    // Monitor: pop and compare on every write strobe, count frame_done pulses
    always @(negedge Pclk) begin
        exp_t e;
        if (write8 === 1'b1) begin
            wr_cnt8 = wr_cnt8 + 1;
            last_a8 = addr8;
            checks  = checks + 1;
            if (q8.size() == 0) begin
                failures = failures + 1;
                $display("FAIL wr8_unexpected addr=%0d data=%h", addr8, data8);
            end else begin
                e = q8.pop_front();
                if (addr8 !== e.a || data8 !== e.d8) begin
                    failures = failures + 1;
                    $display("FAIL wr8 got addr=%0d data=%h exp addr=%0d data=%h",
                             addr8, data8, e.a, e.d8);
                end
            end
        end
        if (write16 === 1'b1) begin
            wr_cnt16 = wr_cnt16 + 1;
            last_a16 = addr16;
            checks   = checks + 1;
            if (q16.size() == 0) begin
                failures = failures + 1;
                $display("FAIL wr16_unexpected addr=%0d data=%h", addr16, data16);
            end else begin
                e = q16.pop_front();
                if (addr16 !== e.a || data16 !== e.d16) begin
                    failures = failures + 1;
                    $display("FAIL wr16 got addr=%0d data=%h exp addr=%0d data=%h",
                             addr16, data16, e.a, e.d16);
                end
            end
        end
        if (done8 === 1'b1)  done_cnt   = done_cnt + 1;
        if (done16 === 1'b1) done_cnt16 = done_cnt16 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Pclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive one Href line; push expected writes for stored pixels
    task automatic send_line(input logic [7:0] b1, input logic [7:0] b2, input int npix,
                             input bit odd, input int row, input bit exp_en,
                             input logic [7:0] e8, input logic [15:0] e16);
        exp_t e;
        for (int p = 0; p < npix; p++) begin
            if (exp_en && p < 4 && row < 2) begin
                e.a   = 3'(row * 4 + p);
                e.d8  = e8;
                e.d16 = e16;
                q8.push_back(e);
                q16.push_back(e);
            end
            Href = 1'b1;
            D    = b1;
            tick(1);
            D    = b2;
            tick(1);
        end
        if (odd) begin
            D = 8'h55;
            tick(1);
        end
        Href = 1'b0;
        D    = 8'h00;
        tick(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (q8.size() == 0 && q16.size() == 0) break;
            tick(1);
        end
        chk(name, 32'(q8.size() + q16.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int wc;
        Rst_n = 1'b0; Vsync = 1'b1; Href = 1'b0; D = 8'h00; Enable = 1'b0; Single = 1'b1;
        tick(3);
        chk("rst_addr", 32'(addr8), 0);
        chk("rst_data", 32'(data8), 0);
        chk("rst_write", 32'(write8), 0);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_lerr", 32'(lerr8), 0);
        chk("rst_data16", 32'(data16), 0);
        Rst_n = 1'b1;

        // Frame A: 4x2 of E5/1B; Enable dropped mid-frame, frame still completes
        Enable = 1'b1;
        tick(4);
        chk("armed_busy", 32'(busy8), 1);
        Vsync = 1'b0;
        tick(3);
        send_line(8'hE5, 8'h1B, 4, 1'b0, 0, 1'b1, 8'hF7, 16'hE51B);
        send_line(8'hE5, 8'h1B, 4, 1'b0, 1, 1'b1, 8'hF7, 16'hE51B);
        Enable = 1'b0;
        Vsync  = 1'b1;
        tick(4);
        drain("a_drain");
        chk("a_writes", 32'(wr_cnt8), 8);
        chk("a_last_addr8", 32'(last_a8), 7);
        chk("a_last_addr16", 32'(last_a16), 7);
        chk("a_done", 32'(done_cnt), 1);
        chk("a_done16", 32'(done_cnt16), 1);
        chk("a_lerr", 32'(lerr8), 0);
        chk("a_idle", 32'(busy8), 0);

        // Href activity in IDLE must not write
        Vsync = 1'b0;
        tick(3);
        send_line(8'hE5, 8'h1B, 4, 1'b0, 0, 1'b0, 8'h00, 16'h0000);
        Vsync = 1'b1;
        tick(3);
        chk("idle_nowrite", 32'(wr_cnt8), 8);

        // Frame B: 3 lines of 6 pixels, continuous mode
        Enable = 1'b1;
        Single = 1'b0;
        tick(4);
        Vsync = 1'b0;
        tick(3);
        for (int r = 0; r < 3; r++) begin
            send_line(8'h12, 8'h34, 6, 1'b0, r, 1'b1, 8'h0A, 16'h1234);
        end
        chk("b_lerr", 32'(lerr8), 1);
        Vsync = 1'b1;
        tick(4);
        drain("b_drain");
        chk("b_writes", 32'(wr_cnt16), 16);
        chk("b_done", 32'(done_cnt), 2);
        chk("b_rearmed", 32'(busy8), 1);

        // Frame C: 7-byte line then a full line; line_err sticky to next frame
        Single = 1'b1;
        Vsync  = 1'b0;
        tick(3);
        chk("c_lerr_clr", 32'(lerr8), 0);
        send_line(8'hA5, 8'h5A, 3, 1'b1, 0, 1'b1, 8'hB7, 16'hA55A);
        chk("c_lerr_set", 32'(lerr8), 1);
        send_line(8'hFF, 8'hFF, 4, 1'b0, 1, 1'b1, 8'hFF, 16'hFFFF);
        Vsync = 1'b1;
        tick(4);
        drain("c_drain");
        chk("c_writes", 32'(wr_cnt8), 23);
        chk("c_lerr_hold", 32'(lerr8), 1);
        chk("c_done", 32'(done_cnt), 3);

        // Frame D: reset after 3 writes mid-line
        tick(2);
        Vsync = 1'b0;
        tick(3);
        chk("d_lerr_clr", 32'(lerr8), 0);
        for (int p = 0; p < 3; p++) begin
            exp_t e;
            e.a = 3'(p); e.d8 = 8'hF7; e.d16 = 16'hE51B;
            q8.push_back(e);
            q16.push_back(e);
            Href = 1'b1;
            D = 8'hE5;
            tick(1);
            D = 8'h1B;
            tick(1);
        end
        D = 8'hE5;
        tick(1);
        Rst_n = 1'b0;
        tick(1);
        chk("d_rst_write", 32'(write8), 0);
        chk("d_rst_addr", 32'(addr8), 0);
        chk("d_rst_data", 32'(data8), 0);
        chk("d_rst_busy", 32'(busy8), 0);
        chk("d_rst_data16", 32'(data16), 0);
        chk("d_pre_writes", 32'(wr_cnt8), 26);
        Rst_n = 1'b1;
        Href  = 1'b0;
        D     = 8'h00;
        tick(3);
        // No Vsync fall seen since reset: nothing captured
        send_line(8'hE5, 8'h1B, 4, 1'b0, 0, 1'b0, 8'h00, 16'h0000);
        wc = wr_cnt8;
        chk("d_nofall", 32'(wc), 26);
        Vsync = 1'b1;
        tick(4);
        Vsync = 1'b0;
        tick(3);
        send_line(8'h12, 8'h34, 4, 1'b0, 0, 1'b1, 8'h0A, 16'h1234);
        Vsync = 1'b1;
        tick(4);
        drain("d_drain");
        chk("d_writes", 32'(wr_cnt8), 30);
        chk("d_last_addr", 32'(last_a8), 3);
        chk("d_done", 32'(done_cnt), 4);
        chk("d_lerr", 32'(lerr8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/captura_pixeles.md
CAPTURA_PIXELES -- requirements
Module: captura_pixeles

Interface
REQ-001 Parameter H_PIX, default 160, stored pixels per line.
REQ-002 Parameter V_PIX, default 120, stored lines per frame.
REQ-003 Parameter AW, default 15, address width; SHALL satisfy 2^AW >= H_PIX*V_PIX.
REQ-004 Parameter OUT_FMT, default 0, output format: 0 RGB332, 1 RGB444, 2 RGB565.
REQ-005 Derived DW: 8 / 12 / 16 for OUT_FMT 0 / 1 / 2.
REQ-006 Pclk  in  1  sole clock; all logic on rising edge.
REQ-007 Rst_n  in  1  reset, synchronous, active-low.
REQ-008 Vsync  in  1  sensor frame sync; high = vertical blank.
REQ-009 Href  in  1  sensor line valid.
REQ-010 D  in  8  sensor byte, RGB565, high byte first.
REQ-011 Enable  in  1  arm capture; level-sensitive.
REQ-012 Single  in  1  1 = stop after one frame.
REQ-013 addr  out  AW  frame-buffer write address.
REQ-014 data  out  DW  packed pixel.
REQ-015 write  out  1  one-cycle write strobe.
REQ-016 frame_done  out  1  one-cycle pulse at frame end.
REQ-017 line_err  out  1  sticky malformed-line flag.
REQ-018 busy  out  1  high in ARMED or CAPTURE.

Function
REQ-019 Vsync and Href registered once; all edges detected on registered copies (vs_q, hr_q).
REQ-020 FSM states IDLE, ARMED, CAPTURE; IDLE -> ARMED when Enable=1.
REQ-021 ARMED -> CAPTURE on vs_q falling edge; col, row, byte phase, line_err cleared on that edge.
REQ-022 CAPTURE -> on vs_q rising edge: frame_done=1 for one cycle; next state IDLE if Single=1 or Enable=0, else ARMED.
REQ-023 Enable deasserted during CAPTURE: current frame completes; no abort.
REQ-024 In CAPTURE with hr_q=1, byte phase toggles each cycle; phase 0 latches byte b1, phase 1 forms pixel from b1 and current byte b2.
REQ-025 Packing: RGB332 = {b1[7:5], b1[2:0], b2[4:3]}; RGB444 = {b1[7:4], b1[2:0], b2[7], b2[4:1]}; RGB565 = {b1, b2}.
REQ-026 On phase 1 with col<H_PIX and row<V_PIX: data, addr = row*H_PIX+col, write=1 registered at that edge; col increments.
REQ-027 addr generated incrementally (line base + col); no multiplier.
REQ-028 Pixels with col>=H_PIX or lines with row>=V_PIX discarded: write stays 0, addr never exceeds H_PIX*V_PIX-1.
REQ-029 hr_q falling edge: row increments, col and phase clear.
REQ-030 line_err set at hr_q falling edge when row<V_PIX and (col!=H_PIX or phase=1); odd trailing byte dropped.
REQ-031 Href activity outside CAPTURE ignored; write=0.
REQ-032 Vsync rising while Href high: frame ends; partial pixel dropped, no write.

Reset
REQ-033 Rst_n=0 at any edge, including mid-frame: state IDLE; addr, data, write, frame_done, line_err, busy all 0; counters 0.
REQ-034 After reset, first frame captured only after a full Vsync falling edge seen in ARMED.

Configuration
REQ-035 Macro CAPTURA_DECIM_EN defined: 2:1 decimation both axes; only even sensor pixels of even sensor lines stored; col/row count stored pixels; line_err compares against 2*H_PIX sensor pixels.
REQ-036 Macro undefined: every sensor pixel stored; no decimation logic present.

Structure
REQ-037 Shared package holds FSM state encoding, OUT_FMT constants, and DW derivation function.
REQ-038 One sub-module, pixel_empaquetador: combinational b1,b2 -> data per OUT_FMT.

Verification
REQ-039 H_PIX=4, V_PIX=2, OUT_FMT=0, Enable=1, Single=1; bytes b1=8'hE5, b2=8'h1B -> write at addr 0..7, data 8'hF7 each; one frame_done; state IDLE after.
REQ-040 OUT_FMT=2, same frame -> data 16'hE51B; last addr 7.
REQ-041 Line of 6 pixels with H_PIX=4 -> exactly 4 writes per line, line_err=1; third line with V_PIX=2 -> no write.
REQ-042 Line with 7 bytes -> 3 writes, line_err=1 until next frame start.
REQ-043 Rst_n=0 after 3 writes mid-frame -> all outputs 0 next cycle; next Vsync fall captures from addr 0.
REQ-044 CAPTURA_DECIM_EN, H_PIX=2, V_PIX=1, sensor line of 4 pixels -> writes of pixels 0 and 2 at addr 0, 1.
